// File: rtl/dmem_pkg.sv
// -----------------------------------------------------------------------------
// dmem_pkg
// Shared definitions for the data-memory responder: RV32I load/store funct3
// codes, the responder state encoding and sign-extension helpers.
// -----------------------------------------------------------------------------
package dmem_pkg;

    // RV32I load/store size/sign encodings
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Responder state encoding
    typedef enum logic [1:0] {
        S_IDLE   = 2'b00,
        S_WAIT   = 2'b01,
        S_ACCESS = 2'b10
    } state_e;

    // Sign-extend a byte to a 32-bit word
    function automatic logic [31:0] sext8(input logic [7:0] b);
        return {{24{b[7]}}, b};
    endfunction

    // Sign-extend a halfword to a 32-bit word
    function automatic logic [31:0] sext16(input logic [15:0] h);
        return {{16{h[15]}}, h};
    endfunction

endpackage

// File: rtl/dmem_align.sv
// -----------------------------------------------------------------------------
// dmem_align
// Combinational lane steering for the data memory.
// Stores: builds the 4-bit byte write mask and the lane-replicated store word.
// Loads : picks the addressed byte/halfword out of the read word and extends it.
// Fault : flags invalid funct3 (and, with DMEM_MISALIGN_TRAP_EN defined,
//         misaligned halfword/word accesses). A faulting access gets an
//         all-zero write mask and a zero load value.
// Without DMEM_MISALIGN_TRAP_EN, misaligned accesses are force-aligned:
// halfwords use addr[1] only and words ignore addr[1:0].
//
// Ports:
//   addr_i   [1:0]  byte offset within the word
//   funct3_i [2:0]  RV32I access size/sign
//   write_i         1 = store, 0 = load
//   wdata_i  [31:0] right-justified store data
//   rword_i  [31:0] word read from the array
//   be_o     [3:0]  byte write enables
//   wword_o  [31:0] store data replicated onto every lane
//   rdata_o  [31:0] right-justified, extended load value
//   fault_o         misalign/invalid flag
// -----------------------------------------------------------------------------
module dmem_align
    import dmem_pkg::*;
(
    input  logic [1:0]  addr_i,
    input  logic [2:0]  funct3_i,
    input  logic        write_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rword_i,
    output logic [3:0]  be_o,
    output logic [31:0] wword_o,
    output logic [31:0] rdata_o,
    output logic        fault_o
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;
    logic [3:0]  be_s;
    logic [31:0] ld_s;
    logic        invalid_s;
    logic        fault_s;

    // Addressed byte and (force-aligned) halfword of the read word
    always_comb begin
        case (addr_i)
            2'b00:   byte_s = rword_i[7:0];
            2'b01:   byte_s = rword_i[15:8];
            2'b10:   byte_s = rword_i[23:16];
            default: byte_s = rword_i[31:24];
        endcase
        if (addr_i[1]) begin
            half_s = rword_i[31:16];
        end else begin
            half_s = rword_i[15:0];
        end
    end

    // Per-funct3 mask, store replication, load extension and validity
    always_comb begin
        be_s      = 4'b0000;
        wword_o   = 32'h0000_0000;
        ld_s      = 32'h0000_0000;
        invalid_s = 1'b0;
        case (funct3_i)
            F3_B: begin
                be_s    = 4'b0001 << addr_i;
                wword_o = {4{wdata_i[7:0]}};
                ld_s    = sext8(byte_s);
            end
            F3_H: begin
                be_s    = addr_i[1] ? 4'b1100 : 4'b0011;
                wword_o = {2{wdata_i[15:0]}};
                ld_s    = sext16(half_s);
            end
            F3_W: begin
                be_s    = 4'b1111;
                wword_o = wdata_i;
                ld_s    = rword_i;
            end
            // Unsigned variants exist only for loads
            F3_BU: begin
                ld_s      = {24'h00_0000, byte_s};
                invalid_s = write_i;
            end
            F3_HU: begin
                ld_s      = {16'h0000, half_s};
                invalid_s = write_i;
            end
            default: begin
                invalid_s = 1'b1;
            end
        endcase
    end

`ifdef DMEM_MISALIGN_TRAP_EN
    logic is_half_s;
    logic is_word_s;
    logic misalign_s;
    assign is_half_s  = (funct3_i == F3_H) || (funct3_i == F3_HU);
    assign is_word_s  = (funct3_i == F3_W);
    assign misalign_s = (is_half_s && addr_i[0]) || (is_word_s && (addr_i != 2'b00));
    assign fault_s    = invalid_s || misalign_s;
`else
    assign fault_s    = invalid_s;
`endif

    assign fault_o = fault_s;
    assign be_o    = fault_s ? 4'b0000 : be_s;
    assign rdata_o = fault_s ? 32'h0000_0000 : ld_s;

endmodule

// File: rtl/dmem_responder.sv
// -----------------------------------------------------------------------------
// dmem_responder
// Memory-side responder for the CPU data port. Captures a level-held request
// in IDLE, waits LATENCY cycles, performs one array access in ACCESS and then
// pulses o_ack for one cycle with registered o_rdata/o_err.
// Build option: DMEM_MISALIGN_TRAP_EN (misaligned/invalid accesses fault with
// o_err = 1; otherwise o_err is constant 0 and misaligned accesses are
// force-aligned).
//
// Ports:
//   i_clk     CPU clock
//   i_rst_n   asynchronous active-low reset
//   i_req     request, held high until ack
//   i_addr    byte address (bits above the array index wrap)
//   i_wdata   right-justified store data
//   i_funct3  RV32I load/store funct3
//   i_write   0 = read, 1 = write
//   o_ack     one-cycle completion pulse
//   o_rdata   load result, valid with o_ack (0 for stores)
//   o_err     access fault, qualified by o_ack
// -----------------------------------------------------------------------------
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int    XLEN        = 32,
    parameter int    DEPTH_WORDS = 1024,
    parameter int    LATENCY     = 1,
    parameter string INIT_FILE   = ""
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_req,
    input  logic [XLEN-1:0] i_addr,
    input  logic [XLEN-1:0] i_wdata,
    input  logic [2:0]      i_funct3,
    input  logic            i_write,
    output logic            o_ack,
    output logic [XLEN-1:0] o_rdata,
    output logic            o_err
);

    localparam int         AW     = $clog2(DEPTH_WORDS);
    localparam logic [3:0] LAT_M1 = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

    state_e          state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic [AW+1:0]   addr_q, addr_d;
    logic [XLEN-1:0] wdata_q, wdata_d;
    logic [2:0]      funct3_q, funct3_d;
    logic            write_q, write_d;
    logic            ack_q, ack_d;
    logic [XLEN-1:0] rdata_q, rdata_d;
    logic            err_q, err_d;

    logic [31:0]     mem_q [DEPTH_WORDS];

    logic [AW-1:0]   idx_s;
    logic [31:0]     rword_s;
    logic [3:0]      be_s;
    logic [31:0]     wword_s;
    logic [31:0]     ld_s;
    logic            fault_s;
    logic            commit_s;

    // Address bits above the array index are deliberately ignored (wrap)
    logic unused_addr_s;
    assign unused_addr_s = ^i_addr[XLEN-1:AW+2];

    assign idx_s   = addr_q[AW+1:2];
    assign rword_s = mem_q[idx_s];

    dmem_align u_align (
        .addr_i   (addr_q[1:0]),
        .funct3_i (funct3_q),
        .write_i  (write_q),
        .wdata_i  (wdata_q),
        .rword_i  (rword_s),
        .be_o     (be_s),
        .wword_o  (wword_s),
        .rdata_o  (ld_s),
        .fault_o  (fault_s)
    );

    // Next-state, request latch, wait counter and response generation
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        funct3_d = funct3_q;
        write_d  = write_q;
        ack_d    = 1'b0;
        rdata_d  = '0;
        err_d    = 1'b0;
        commit_s = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (i_req) begin
                    addr_d   = i_addr[AW+1:0];
                    wdata_d  = i_wdata;
                    funct3_d = i_funct3;
                    write_d  = i_write;
                    if (LATENCY > 0) begin
                        state_d = S_WAIT;
                        cnt_d   = LAT_M1;
                    end else begin
                        state_d = S_ACCESS;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = S_ACCESS;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_ACCESS: begin
                // Store commits on the same edge that raises o_ack
                ack_d    = 1'b1;
                commit_s = write_q;
                if (write_q) begin
                    rdata_d = '0;
                end else begin
                    rdata_d = ld_s;
                end
`ifdef DMEM_MISALIGN_TRAP_EN
                err_d    = fault_s;
`else
                err_d    = 1'b0;
`endif
                state_d  = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

`ifndef DMEM_MISALIGN_TRAP_EN
    // Fault already zeroes the mask and load value inside the aligner
    logic unused_fault_s;
    assign unused_fault_s = fault_s;
`endif

    // Control, latched request and registered response
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= 4'd0;
            addr_q   <= '0;
            wdata_q  <= '0;
            funct3_q <= 3'b000;
            write_q  <= 1'b0;
            ack_q    <= 1'b0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            funct3_q <= funct3_d;
            write_q  <= write_d;
            ack_q    <= ack_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
        end
    end

    // Byte-enabled array write; contents are intentionally not reset
    always_ff @(posedge i_clk) begin
        if (commit_s) begin
            for (int k = 0; k < 4; k++) begin
                if (be_s[k]) begin
                    mem_q[idx_s][8*k +: 8] <= wword_s[8*k +: 8];
                end
            end
        end
    end

    assign o_ack   = ack_q;
    assign o_rdata = rdata_q;
    assign o_err   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// -----------------------------------------------------------------------------
// tb_dmem_responder
// Two responders: index 0 with LATENCY=1, index 1 with LATENCY=0. Stimulus
// tasks push the expected response into a per-DUT queue; a monitor pops and
// compares on every o_ack.
// -----------------------------------------------------------------------------
module tb_dmem_responder;

`ifdef DMEM_MISALIGN_TRAP_EN
    localparam logic TRAP = 1'b1;
`else
    localparam logic TRAP = 1'b0;
`endif

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req   [2];
    logic [31:0] addr  [2];
    logic [31:0] wdata [2];
    logic [2:0]  f3    [2];
    logic        wr    [2];
    logic        ack   [2];
    logic [31:0] rdata [2];
    logic        err   [2];

    exp_t sbq [2][$];
    exp_t e_m;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    dmem_responder #(.XLEN(32), .DEPTH_WORDS(1024), .LATENCY(1), .INIT_FILE("")) u_l1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_req(req[0]), .i_addr(addr[0]),
        .i_wdata(wdata[0]), .i_funct3(f3[0]), .i_write(wr[0]),
        .o_ack(ack[0]), .o_rdata(rdata[0]), .o_err(err[0])
    );

    dmem_responder #(.XLEN(32), .DEPTH_WORDS(1024), .LATENCY(0), .INIT_FILE("")) u_l0 (
        .i_clk(clk), .i_rst_n(rst_n), .i_req(req[1]), .i_addr(addr[1]),
        .i_wdata(wdata[1]), .i_funct3(f3[1]), .i_write(wr[1]),
        .o_ack(ack[1]), .o_rdata(rdata[1]), .o_err(err[1])
    );

    function automatic int lat(input int d);
        return (d == 0) ? 1 : 0;
    endfunction

    // Scoreboard monitor
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (ack[d] === 1'b1) begin
                total++;
                if (sbq[d].size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_ack dut%0d: got rdata=%h err=%b, required no ack", d, rdata[d], err[d]);
                end else begin
                    e_m = sbq[d].pop_front();
                    if (rdata[d] !== e_m.rdata || err[d] !== e_m.err) begin
                        bad++;
                        $display("FAIL resp dut%0d: got rdata=%h err=%b, required rdata=%h err=%b",
                                 d, rdata[d], err[d], e_m.rdata, e_m.err);
                    end
                end
            end
        end
    end

    task automatic push_exp(input int d, input logic [31:0] er, input logic ee);
        exp_t e;
        e.rdata = er;
        e.err   = ee;
        sbq[d].push_back(e);
    endtask

    // Wait for one ack, up to a bound; returns negedges elapsed
    task automatic wait_ack(input int d, output int cyc, output logic got);
        cyc = 0;
        got = 1'b0;
        while (!got && cyc < 20) begin
            @(negedge clk);
            cyc++;
            if (ack[d] === 1'b1) got = 1'b1;
        end
    endtask

    task automatic access(input int d, input logic w, input logic [31:0] a, input logic [31:0] wd,
                          input logic [2:0] f, input logic [31:0] er, input logic ee, input string name);
        int   cyc;
        logic got;
        @(negedge clk);
        req[d] = 1'b1; wr[d] = w; addr[d] = a; wdata[d] = wd; f3[d] = f;
        push_exp(d, er, ee);
        wait_ack(d, cyc, got);
        req[d] = 1'b0;
        total++;
        if (!got || cyc != lat(d) + 2) begin
            bad++;
            $display("FAIL %s_latency dut%0d: got ack=%b after %0d cycles, required ack after %0d", name, d, got, cyc, lat(d) + 2);
        end
        @(negedge clk);
        total++;
        if (ack[d] !== 1'b0 || rdata[d] !== 32'h0 || err[d] !== 1'b0) begin
            bad++;
            $display("FAIL %s_post dut%0d: got ack=%b rdata=%h err=%b, required all 0", name, d, ack[d], rdata[d], err[d]);
        end
    endtask

    task automatic sw(input int d, input logic [31:0] a, input logic [31:0] wd, input string name);
        access(d, 1'b1, a, wd, 3'b010, 32'h0, 1'b0, name);
    endtask

    task automatic ld(input int d, input logic [31:0] a, input logic [2:0] f,
                      input logic [31:0] er, input logic ee, input string name);
        access(d, 1'b0, a, 32'h0, f, er, ee, name);
    endtask

    task automatic check_idle(input string name);
        for (int d = 0; d < 2; d++) begin
            total++;
            if (ack[d] !== 1'b0 || rdata[d] !== 32'h0 || err[d] !== 1'b0) begin
                bad++;
                $display("FAIL %s dut%0d: got ack=%b rdata=%h err=%b, required all 0", name, d, ack[d], rdata[d], err[d]);
            end
        end
    endtask

    initial begin
        int   cyc;
        logic got;
        logic [31:0] b2b_addr [4];
        logic [31:0] b2b_data [4];
        b2b_addr = '{32'h0000_0000, 32'h0000_0004, 32'h0000_0008, 32'h0000_000C};
        b2b_data = '{32'h0A0B_0C0D, 32'h8000_0001, 32'hFFFF_0000, 32'h1357_9BDF};

        rst_n = 1'b0;
        for (int d = 0; d < 2; d++) begin
            req[d] = 1'b0; wr[d] = 1'b0; addr[d] = 32'h0; wdata[d] = 32'h0; f3[d] = 3'b000;
        end
        #2;
        check_idle("reset_outputs");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Word store/load
        sw(0, 32'h0000_0100, 32'hDEAD_BEEF, "sw_100");
        ld(0, 32'h0000_0100, 3'b010, 32'hDEAD_BEEF, 1'b0, "lw_100");

        // Sub-word loads
        sw(0, 32'h0000_0200, 32'h80FF_7F01, "sw_200");
        ld(0, 32'h0000_0203, 3'b000, 32'hFFFF_FF80, 1'b0, "lb_203");
        ld(0, 32'h0000_0201, 3'b100, 32'h0000_007F, 1'b0, "lbu_201");
        ld(0, 32'h0000_0202, 3'b001, 32'hFFFF_80FF, 1'b0, "lh_202");
        ld(0, 32'h0000_0200, 3'b101, 32'h0000_7F01, 1'b0, "lhu_200");

        // Sub-word stores
        sw(0, 32'h0000_0300, 32'h0000_0000, "sw_300");
        access(0, 1'b1, 32'h0000_0301, 32'h0000_00AA, 3'b000, 32'h0, 1'b0, "sb_301");
        access(0, 1'b1, 32'h0000_0302, 32'h0000_1234, 3'b001, 32'h0, 1'b0, "sh_302");
        ld(0, 32'h0000_0300, 3'b010, 32'h1234_AA00, 1'b0, "lw_300");

        // Address wrap above the array depth (4 KiB)
        ld(0, 32'h0000_1100, 3'b010, 32'hDEAD_BEEF, 1'b0, "lw_wrap");

        // Invalid funct3
        ld(0, 32'h0000_0100, 3'b011, 32'h0, TRAP, "ld_f3_011");
        ld(0, 32'h0000_0100, 3'b111, 32'h0, TRAP, "ld_f3_111");
        access(0, 1'b1, 32'h0000_0100, 32'h0, 3'b011, 32'h0, TRAP, "st_f3_011");
        ld(0, 32'h0000_0100, 3'b010, 32'hDEAD_BEEF, 1'b0, "lw_after_bad_st");

        // Misaligned word store
        sw(0, 32'h0000_0400, 32'h1111_1111, "sw_400");
        access(0, 1'b1, 32'h0000_0402, 32'hCAFE_F00D, 3'b010, 32'h0, TRAP, "sw_402");
        ld(0, 32'h0000_0400, 3'b010, TRAP ? 32'h1111_1111 : 32'hCAFE_F00D, 1'b0, "lw_400");

        // Reset during WAIT of a store
        sw(0, 32'h0000_0500, 32'h5555_5555, "sw_500");
        @(negedge clk);
        req[0] = 1'b1; wr[0] = 1'b1; addr[0] = 32'h0000_0500; wdata[0] = 32'hA5A5_A5A5; f3[0] = 3'b010;
        @(negedge clk);
        rst_n  = 1'b0;
        req[0] = 1'b0;
        #1;
        check_idle("in_reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        check_idle("after_reset");
        ld(0, 32'h0000_0500, 3'b010, 32'h5555_5555, 1'b0, "lw_500_kept");

        // LATENCY=0: fill, then back-to-back reads with req held high
        for (int k = 0; k < 4; k++) sw(1, b2b_addr[k], b2b_data[k], "sw_l0");
        @(negedge clk);
        req[1] = 1'b1; wr[1] = 1'b0; f3[1] = 3'b010; addr[1] = b2b_addr[0];
        push_exp(1, b2b_data[0], 1'b0);
        for (int k = 0; k < 4; k++) begin
            wait_ack(1, cyc, got);
            total++;
            if (!got || cyc != 2) begin
                bad++;
                $display("FAIL b2b_spacing read%0d: got ack=%b after %0d cycles, required ack after 2", k, got, cyc);
            end
            if (k < 3) begin
                addr[1] = b2b_addr[k+1];
                push_exp(1, b2b_data[k+1], 1'b0);
            end else begin
                req[1] = 1'b0;
            end
        end
        repeat (3) @(negedge clk);
        check_idle("b2b_done");

        // Every pushed expectation must have been consumed
        for (int d = 0; d < 2; d++) begin
            total++;
            if (sbq[d].size() != 0) begin
                bad++;
                $display("FAIL pending dut%0d: got %0d unmatched expectations, required 0", d, sbq[d].size());
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
